aes_key_expand_ctrl: RTL

Sequencer that expands a 128-bit AES cipher key into the 11 round keys (rk0..rk10). It drives the external registered one-round key-schedule datapath (round number in, previous key in, next key out one clock later) and stores every round key in a local register file. The cipher core reads round keys through a registered read port. It accepts a new key through a valid/ready handshake and signals completion with keys_valid.

---
 rtl/aes_key_expand_ctrl.sv | 71 +++++++
 1 files changed

// File: rtl/aes_key_expand_ctrl.sv
// aes_key_expand_ctrl: sequences an external one-round AES-128 key-schedule datapath
// and stores the 11 round keys in a local file with a registered read port.
module aes_key_expand_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             flush,
    output logic [3:0]       ks_round,
    output logic [KEY_W-1:0] ks_in,
    input  logic [KEY_W-1:0] ks_out,
    output logic             busy,
    output logic             keys_valid,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key
);
    typedef enum logic [1:0] {IDLE, EXP, CAP, DONE} state_t;
    state_t state, state_nxt;
    logic [3:0] r;
    logic [KEY_W-1:0] last_key;
    logic [KEY_W-1:0] rk [0:NUM_ROUNDS];
    logic accept, last_round;
    assign accept     = key_valid && key_ready;
    assign last_round = r == 4'(NUM_ROUNDS);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = flush ? IDLE :
                    accept ? EXP :
                    (state == EXP) ? CAP :
                    (state == CAP) ? (last_round ? DONE : EXP) : state;
    end
    // Round code 11 outside EXP makes the datapath hold its registered output.
    always_comb begin
        key_ready = (state == IDLE) || (state == DONE);
        busy      = (state == EXP) || (state == CAP);
        ks_round  = (state == EXP) ? r : 4'd11;
        ks_in     = last_key;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r          <= '0;
            last_key   <= '0;
            keys_valid <= 1'b0;
            rd_key     <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
        end else begin
            rd_key <= (rd_idx <= 4'(NUM_ROUNDS)) ? rk[rd_idx] : '0;
            if (flush) begin
                keys_valid <= 1'b0;
                r          <= '0;
            end else if (accept) begin
                rk[0]      <= key_in;
                last_key   <= key_in;
                r          <= 4'd1;
                keys_valid <= 1'b0;
            end else if (state == CAP) begin
                rk[r]    <= ks_out;
                last_key <= ks_out;
                if (last_round) keys_valid <= 1'b1;
                else            r <= r + 4'd1;
            end
        end
    end
endmodule
